// File: rtl/sar_pkg.sv
// Shared types and defaults for the SAR ADC controller: state encoding,
// default parameter values and the MSB one-hot helper.
package sar_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CONV   = 3'd3,
    ST_CAL    = 3'd4,
    ST_DONE   = 3'd5
  } sar_state_e;

  localparam int DEF_RES_BITS  = 10;
  localparam int DEF_TRIM_BITS = 5;
  localparam int DEF_CAL_VOTES = 8;
  localparam int DEF_AVG_LOG2  = 2;

  // One-hot word with only bit (w-1) set; callers size-cast to their width.
  function automatic logic [31:0] msb_onehot(input int unsigned w);
    msb_onehot = 32'd1 << (w - 32'd1);
  endfunction

endpackage

// File: rtl/sar_cal_vote.sv
// Majority-vote accumulator for offset calibration: counts CAL_VOTES comparator
// decisions per trim bit, then flags a decision cycle and whether net > 0.
module sar_cal_vote
  import sar_pkg::*;
#(
  parameter int CAL_VOTES = DEF_CAL_VOTES
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr_i,
  input  logic run_i,
  input  logic comp_i,
  output logic decide_o,
  output logic set_o
);

  // Net counter is wide enough to hold +/-CAL_VOTES without wrapping.
  localparam int CW = $clog2(CAL_VOTES + 1);
  localparam int NW = CW + 1;

  logic signed [NW-1:0] net_q, net_d;
  logic        [CW-1:0] cnt_q, cnt_d;

  assign decide_o = (cnt_q == CW'(CAL_VOTES));
  assign set_o    = ~net_q[NW-1] & (net_q != {NW{1'b0}});

  // Vote counting; a decision cycle clears both counters for the next bit.
  always_comb begin
    net_d = net_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      net_d = {NW{1'b0}};
      cnt_d = {CW{1'b0}};
    end else if (run_i) begin
      if (decide_o) begin
        net_d = {NW{1'b0}};
        cnt_d = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1'b1);
        net_d = comp_i ? (net_q - NW'(1'b1)) : (net_q + NW'(1'b1));
      end
    end else begin
      net_d = net_q;
      cnt_d = cnt_q;
    end
  end

  // Counter state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      net_q <= {NW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      net_q <= net_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sar_ctrl_param.sv
// Parametrised SAR ADC controller: binary-search conversion, majority-vote
// comparator trim calibration, continuous mode. SAR_AVG_EN enables averaging.
module sar_ctrl_param
  import sar_pkg::*;
#(
  parameter int RES_BITS  = DEF_RES_BITS,
  parameter int TRIM_BITS = DEF_TRIM_BITS,
  parameter int CAL_VOTES = DEF_CAL_VOTES
`ifdef SAR_AVG_EN
  ,
  parameter int AVG_LOG2  = DEF_AVG_LOG2
`endif
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 cal,
  input  logic                 cont,
  input  logic                 comp,
  output logic                 busy,
  output logic                 valid,
  output logic [RES_BITS-1:0]  result,
  output logic                 sample,
  output logic [RES_BITS-1:0]  ctlp,
  output logic [RES_BITS-1:0]  ctln,
  output logic [TRIM_BITS-1:0] trim,
  output logic [TRIM_BITS-1:0] trimb,
  output logic                 clkc
);

  localparam logic [RES_BITS-1:0]  RES_MSB  = RES_BITS'(msb_onehot(RES_BITS));
  localparam logic [TRIM_BITS-1:0] TRIM_MSB = TRIM_BITS'(msb_onehot(TRIM_BITS));

  sar_state_e           state_q, state_d;
  logic [RES_BITS-1:0]  work_q, work_d;
  logic [RES_BITS-1:0]  mask_q, mask_d;
  logic [TRIM_BITS-1:0] trim_val_q, trim_val_d;
  logic [TRIM_BITS-1:0] trim_mask_q, trim_mask_d;
  logic [RES_BITS-1:0]  result_q, result_d;
  logic                 clk_en_q, clk_en_d;
  logic                 valid_q, valid_d;
  logic                 cal_q, cal_d;
  logic [RES_BITS-1:0]  conv_word_s;
  logic                 vote_clr_s;
  logic                 vote_decide_s;
  logic                 vote_set_s;

`ifdef SAR_AVG_EN
  localparam int ACC_W = RES_BITS + AVG_LOG2;
  localparam int PW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [PW-1:0] LAST_PASS = PW'((1 << AVG_LOG2) - 1);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [PW-1:0]    pass_q, pass_d;
`endif

  sar_cal_vote #(
    .CAL_VOTES (CAL_VOTES)
  ) u_vote (
    .clk      (clk),
    .rstn     (rstn),
    .clr_i    (vote_clr_s),
    .run_i    (state_q == ST_CAL),
    .comp_i   (comp),
    .decide_o (vote_decide_s),
    .set_o    (vote_set_s)
  );

  assign conv_word_s = comp ? (work_q | mask_q) : work_q;

  // Next-state and register-update logic for the conversion/calibration FSM.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    mask_d      = mask_q;
    trim_val_d  = trim_val_q;
    trim_mask_d = trim_mask_q;
    result_d    = result_q;
    clk_en_d    = clk_en_q;
    cal_d       = cal_q;
    valid_d     = 1'b0;
    vote_clr_s  = 1'b0;
`ifdef SAR_AVG_EN
    acc_d       = acc_q;
    pass_d      = pass_q;
`endif
    case (state_q)
      ST_INIT: begin
        trim_val_d = TRIM_MSB;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (en) begin
          work_d   = {RES_BITS{1'b0}};
          mask_d   = RES_MSB;
          clk_en_d = 1'b1;
          cal_d    = cal;
          state_d  = ST_SAMPLE;
`ifdef SAR_AVG_EN
          pass_d   = {PW{1'b0}};
`endif
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_SAMPLE: begin
        if (cal_q) begin
          trim_val_d  = {TRIM_BITS{1'b0}};
          trim_mask_d = TRIM_MSB;
          vote_clr_s  = 1'b1;
          state_d     = ST_CAL;
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        work_d = conv_word_s;
        mask_d = mask_q >> 1;
        if (mask_q[0]) begin
`ifdef SAR_AVG_EN
          acc_d = acc_q + ACC_W'(conv_word_s);
          if (pass_q == LAST_PASS) begin
            clk_en_d = 1'b0;
            state_d  = ST_DONE;
          end else begin
            pass_d  = pass_q + PW'(1'b1);
            work_d  = {RES_BITS{1'b0}};
            mask_d  = RES_MSB;
            state_d = ST_SAMPLE;
          end
`else
          clk_en_d = 1'b0;
          state_d  = ST_DONE;
`endif
        end else begin
          state_d = ST_CONV;
        end
      end
      ST_CAL: begin
        if (vote_decide_s) begin
          // A tie leaves the trim bit clear.
          if (vote_set_s) begin
            trim_val_d = trim_val_q | trim_mask_q;
          end else begin
            trim_val_d = trim_val_q;
          end
          trim_mask_d = trim_mask_q >> 1;
          if (trim_mask_q[0]) begin
            clk_en_d = 1'b0;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_CAL;
          end
        end else begin
          state_d = ST_CAL;
        end
      end
      ST_DONE: begin
        valid_d = 1'b1;
        if (!cal_q) begin
`ifdef SAR_AVG_EN
          result_d = RES_BITS'(acc_q >> AVG_LOG2);
          acc_d    = {ACC_W{1'b0}};
`else
          result_d = work_q;
`endif
        end else begin
          result_d = result_q;
        end
        if (cont && !cal_q) begin
          work_d   = {RES_BITS{1'b0}};
          mask_d   = RES_MSB;
          clk_en_d = 1'b1;
          state_d  = ST_SAMPLE;
`ifdef SAR_AVG_EN
          pass_d   = {PW{1'b0}};
`endif
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        clk_en_d = 1'b0;
        state_d  = ST_WAIT;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_INIT;
      work_q      <= {RES_BITS{1'b0}};
      mask_q      <= {RES_BITS{1'b0}};
      trim_val_q  <= {TRIM_BITS{1'b0}};
      trim_mask_q <= {TRIM_BITS{1'b0}};
      result_q    <= {RES_BITS{1'b0}};
      clk_en_q    <= 1'b0;
      valid_q     <= 1'b0;
      cal_q       <= 1'b0;
`ifdef SAR_AVG_EN
      acc_q       <= {ACC_W{1'b0}};
      pass_q      <= {PW{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      mask_q      <= mask_d;
      trim_val_q  <= trim_val_d;
      trim_mask_q <= trim_mask_d;
      result_q    <= result_d;
      clk_en_q    <= clk_en_d;
      valid_q     <= valid_d;
      cal_q       <= cal_d;
`ifdef SAR_AVG_EN
      acc_q       <= acc_d;
      pass_q      <= pass_d;
`endif
    end
  end

  assign ctlp   = work_q | mask_q;
  assign ctln   = ~(work_q | mask_q);
  assign trim   = trim_val_q | trim_mask_q;
  assign trimb  = ~(trim_val_q | trim_mask_q);
  assign sample = (state_q == ST_SAMPLE) | (state_q == ST_CAL);
  assign busy   = (state_q != ST_INIT) & (state_q != ST_WAIT);
  // Comparator clock runs on the low phase so comp is settled at each posedge.
  assign clkc   = ~clk & clk_en_q;
  assign valid  = valid_q;
  assign result = result_q;

endmodule

// File: tb/tb_sar_ctrl_param.sv
// Directed self-checking bench for sar_ctrl_param (RES_BITS=10, TRIM_BITS=5, CAL_VOTES=8).
module tb_sar_ctrl_param;

  localparam int RB = 10;
  localparam int TB = 5;
  localparam int CV = 8;

  logic          clk;
  logic          rstn;
  logic          en;
  logic          cal;
  logic          cont;
  logic          comp;
  logic          busy;
  logic          valid;
  logic [RB-1:0] result;
  logic          sample;
  logic [RB-1:0] ctlp;
  logic [RB-1:0] ctln;
  logic [TB-1:0] trim;
  logic [TB-1:0] trimb;
  logic          clkc;

  int checks;
  int errors;
  int m;
  int mode;
  int pidx;
  int vcount;
  int vlast;
  int scount;
  logic [RB-1:0] vin;

  sar_ctrl_param #(
    .RES_BITS  (RB),
    .TRIM_BITS (TB),
    .CAL_VOTES (CV)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .en     (en),
    .cal    (cal),
    .cont   (cont),
    .comp   (comp),
    .busy   (busy),
    .valid  (valid),
    .result (result),
    .sample (sample),
    .ctlp   (ctlp),
    .ctln   (ctln),
    .trim   (trim),
    .trimb  (trimb),
    .clkc   (clkc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; then drive comp for the next edge from the bench's analogue model.
  task automatic tick();
    @(posedge clk);
    #1;
    m++;
    case (mode)
      0: comp = (ctlp <= vin);
      1: comp = (m >= 2) && (((m - 2) % (CV + 1)) < 3);
      2: comp = (m >= 2) && ((((m - 2) % (CV + 1)) % 2) == 0);
      3: begin
        if (sample === 1'b1) begin
          vin  = RB'(10'h100 + pidx);
          pidx = pidx + 1;
        end
        comp = (ctlp <= vin);
      end
      default: comp = 1'b0;
    endcase
  endtask

  task automatic run(input int n);
    vcount = 0;
    vlast  = 0;
    scount = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      en  = 1'b0;
      cal = 1'b0;
      if (valid === 1'b1) begin
        vcount++;
        vlast = m;
      end
      if (sample === 1'b1) scount++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m      = 0;
    mode   = 0;
    pidx   = 0;
    vin    = 10'h000;
    rstn   = 1'b0;
    en     = 1'b0;
    cal    = 1'b0;
    cont   = 1'b0;
    comp   = 1'b0;

    #3;
    chk("rst_ctlp", ctlp, 32'h000);
    chk("rst_ctln", ctln, 32'h3FF);
    chk("rst_trim", trim, 32'h00);
    chk("rst_trimb", trimb, 32'h1F);
    chk("rst_sample", sample, 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_valid", valid, 32'h0);
    chk("rst_result", result, 32'h000);
    chk("rst_clkc", clkc, 32'h0);

    @(negedge clk);
    rstn = 1'b1;
    run(1);
    chk("init_trim", trim, 32'h10);
    chk("init_trimb", trimb, 32'h0F);
    chk("init_busy", busy, 32'h0);

    // Single conversion of 0x2A5.
    mode = 0;
    vin  = 10'h2A5;
    en   = 1'b1;
    m    = 0;
    run(1);
    chk("conv_sample", sample, 32'h1);
    chk("conv_busy", busy, 32'h1);
    chk("conv_first_trial", ctlp, 32'h200);
    run(11);
    chk("conv_done_ctlp", ctlp, 32'h2A5);
    chk("conv_done_ctln", ctln, 32'h15A);
    chk("conv_no_early_valid", vcount, 32'd0);
    run(1);
    chk("conv_valid_cnt", vcount, 32'd1);
    chk("conv_valid_cycle", vlast, 32'd13);
    chk("conv_result", result, 32'h2A5);
    chk("conv_idle", busy, 32'h0);
    run(3);
    chk("conv_single_pulse", vcount, 32'd0);

    // Calibration, 3 of 8 votes high per bit: net +2 sets every bit.
    mode = 1;
    en   = 1'b1;
    cal  = 1'b1;
    m    = 0;
    run(47);
    chk("cal_no_early_valid", vcount, 32'd0);
    run(1);
    chk("cal_valid_cnt", vcount, 32'd1);
    chk("cal_valid_cycle", vlast, 32'd48);
    chk("cal_trim", trim, 32'h1F);
    chk("cal_trimb", trimb, 32'h00);
    chk("cal_result_kept", result, 32'h2A5);
    chk("cal_idle", busy, 32'h0);

    // Calibration tie: alternating votes leave every bit clear.
    mode = 2;
    en   = 1'b1;
    cal  = 1'b1;
    m    = 0;
    run(48);
    chk("tie_valid_cnt", vcount, 32'd1);
    chk("tie_valid_cycle", vlast, 32'd48);
    chk("tie_trim", trim, 32'h00);
    chk("tie_trimb", trimb, 32'h1F);

    // Continuous conversions of 0x100, re-armed straight from DONE.
    mode = 0;
    vin  = 10'h100;
    cont = 1'b1;
    en   = 1'b1;
    m    = 0;
    run(37);
    chk("cont_valid_cnt", vcount, 32'd3);
    chk("cont_last_valid", vlast, 32'd37);
    chk("cont_sample_cnt", scount, 32'd4);
    chk("cont_result", result, 32'h100);
    cont = 1'b0;
    run(23);
    chk("cont_stop_valid_cnt", vcount, 32'd1);
    chk("cont_stop_valid_cycle", vlast, 32'd49);
    chk("cont_stop_sample_cnt", scount, 32'd0);
    chk("cont_stop_idle", busy, 32'h0);
    chk("cont_stop_result", result, 32'h100);
    chk("trim_persists", trim, 32'h00);

    // Reset in the middle of a conversion.
    vin = 10'h2A5;
    en  = 1'b1;
    m   = 0;
    run(5);
    @(negedge clk);
    #1;
    chk("midconv_clkc_on", clkc, 32'h1);
    chk("midconv_busy", busy, 32'h1);
    rstn = 1'b0;
    #1;
    chk("abort_clkc", clkc, 32'h0);
    chk("abort_ctlp", ctlp, 32'h000);
    chk("abort_ctln", ctln, 32'h3FF);
    chk("abort_busy", busy, 32'h0);
    chk("abort_valid", valid, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    run(1);
    chk("reinit_trim", trim, 32'h10);
    run(15);
    chk("abort_no_valid", vcount, 32'd0);
    chk("abort_result", result, 32'h000);

`ifdef SAR_AVG_EN
    // Four passes of 0x100..0x103 average to 0x101 with one valid.
    mode = 3;
    pidx = 0;
    vin  = 10'h100;
    en   = 1'b1;
    m    = 0;
    run(50);
    chk("avg_valid_cnt", vcount, 32'd1);
    chk("avg_valid_cycle", vlast, 32'd46);
    chk("avg_result", result, 32'h101);
    chk("avg_passes", pidx, 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
